rotary_encoder_counter: RTL and testbench
=========================================

// Module: rotary_encoder_counter
// PURPOSE
// Parametrised quadrature rotary-encoder front end: synchronises and debounces raw A/B
// phases, decodes direction at detent (x1), half (x2) or quad (x4) resolution, flags
// illegal jumps, and keeps a POS_WIDTH position register. Sits between panel encoder
// pins and UI/control logic; emits a one-cycle step pulse plus a direction bit.
// PARAMETERS
// MODE            0  0=x1 (count only on a full 4-state cycle), 1=x2, 2=x4; other values illegal
// DEBOUNCE_CYCLES 4  consecutive stable cycles required to accept a phase change; 0 = bypass
// POS_WIDTH       8  width of ov_position
// PORTS
// i_clk        in   1          system clock, rising edge
// i_reset      in   1          synchronous, active-high reset
// i_phase_a    in   1          raw encoder phase A (asynchronous)
// i_phase_b    in   1          raw encoder phase B (asynchronous)
// i_clear      in   1          synchronous position clear
// o_cnt        out  1          one-cycle step pulse
// o_cnt_cw     out  1          direction of last step: 1=CW, 0=CCW; held between pulses
// o_cnt_err    out  1          one-cycle pulse on illegal phase jump (00<->11, 01<->10)
// ov_position  out  POS_WIDTH  accumulated position
// BEHAVIOUR
// - Phase vector P={B,A}; CW order 00->01->11->10->00, CCW is the reverse.
// - Reset: sync FFs, filtered P and debounce counter = 0; o_cnt=o_cnt_cw=o_cnt_err=0;
//   ov_position=0; x1 FSM = SYNC. Reset mid-sequence discards partial progress, no pulse.
// - Sync: 2-FF synchroniser per phase. Debounce: counter restarts on any change of the
//   synced P; filtered P takes synced P once it differs and held DEBOUNCE_CYCLES cycles.
// - Latency: P sampled at edge k -> o_cnt/o_cnt_err high for the cycle after edge
//   k+3+DEBOUNCE_CYCLES; ov_position updates on that same edge.
// - Illegal jump in filtered P (both bits change): o_cnt_err pulse, no count; x1 FSM -> SYNC.
// - MODE 2: every legal transition is a step, direction from transition.
// - MODE 1: legal transition arriving at 00 or 11 is a step.
// - MODE 0 FSM: SYNC->IDLE when P=00. IDLE: 01->CW1, 10->CCW1.
//   CW1(01): 11->CW2, 00->IDLE. CW2(11): 10->CW3, 01->CW1. CW3(10): 00->IDLE + CW step,
//   11->CW2. CCW1(10): 11->CCW2, 00->IDLE. CCW2(11): 01->CCW3, 10->CCW1.
//   CCW3(01): 00->IDLE + CCW step, 11->CCW2. Backtracking never steps; illegal jump ->
//   error + SYNC. Separate pulses (01,00,10,00) and glitches (00,10,11,10,00) give no step.
// - o_cnt_cw updates only when o_cnt asserts.
// - Position: step adds +1 (CW) or -1 (CCW), modulo 2^POS_WIDTH (wrap both ways).
//   i_clear zeroes ov_position next edge; clear wins over a simultaneous step (o_cnt
//   still pulses).
// CONFIGURATION
// ROTARY_ENCODER_SAT_EN defined: ov_position saturates at 0 and 2^POS_WIDTH-1 instead of
//   wrapping; o_cnt/o_cnt_cw still pulse at the limits, position stays put.
// Not defined: wrap-around arithmetic as above.
// TESTING
// 1 MODE0, DEB=0, 3 CW cycles (01,11,10,00), 1 clk/step -> 3 o_cnt pulses, cw=1, position=3.
// 2 MODE0, DEB=4, 10 clk/step, 3 CCW cycles from position 3 -> position=0; then 1 more
//   -> 255 (wrap), or 0 with ROTARY_ENCODER_SAT_EN.
// 3 MODE0 glitches: 01,00,10,00 / 00,11,00 / 00,10,11,10,00 / 00,01,11,00 -> o_cnt
//   never asserts, o_cnt_cw unchanged; 00->11 jump gives exactly one o_cnt_err pulse.
// 4 MODE2, one CW cycle -> 4 pulses, position +4; MODE1 -> 2 pulses, position +2.
// 5 DEB=4, 2-cycle spike on A between steps -> no filtered change, no pulse, no error.
// 6 Reset asserted at CW2 then released with P=00 -> outputs 0, CW completion needs full cycle;
//   i_clear coincident with step -> position=0.

Source files
------------

// File: rtl/rotary_encoder_counter.sv
// Quadrature rotary-encoder front end: 2-FF sync, debounce, x1/x2/x4 decode, position counter.
// Define ROTARY_ENCODER_SAT_EN to make the position saturate at 0 / max instead of wrapping.
module rotary_encoder_counter #(
   parameter int MODE            = 0,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int POS_WIDTH       = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_phase_a,
   input  logic                 i_phase_b,
   input  logic                 i_clear,
   output logic                 o_cnt,
   output logic                 o_cnt_cw,
   output logic                 o_cnt_err,
   output logic [POS_WIDTH-1:0] ov_position
);

   localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_SYNC, ST_IDLE, ST_CW1, ST_CW2, ST_CW3, ST_CCW1, ST_CCW2, ST_CCW3
   } state_e;

   logic [1:0]           sync1_q, sync2_q;
   logic [1:0]           filt_q, filt_d, prev_q;
   state_e               state_q, state_d;
   logic                 cnt_q, cnt_d, cw_q, cw_d, err_q, err_d;
   logic [POS_WIDTH-1:0] pos_q, pos_d;

   // Next phase vector {B,A} in the clockwise direction.
   function automatic logic [1:0] cw_next(input logic [1:0] p);
      case (p)
         2'b00:   cw_next = 2'b01;
         2'b01:   cw_next = 2'b11;
         2'b11:   cw_next = 2'b10;
         default: cw_next = 2'b00;
      endcase
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
      end else begin
         sync1_q <= {i_phase_b, i_phase_a};
         sync2_q <= sync1_q;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign filt_d = sync2_q;
      end else begin : g_debounce
         // cand_q tracks the value being timed; it follows filt_q while the input is quiet.
         logic [1:0]       cand_q, cand_d;
         logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;

         // NOTE: every output of an always_comb gets a default first so no latch is inferred.
         always_comb begin
            cand_d    = cand_q;
            deb_cnt_d = deb_cnt_q;
            filt_d    = filt_q;
            if (sync2_q == filt_q) begin
               cand_d    = filt_q;
               deb_cnt_d = '0;
            end else if (sync2_q != cand_q) begin
               cand_d    = sync2_q;
               deb_cnt_d = CNT_W'(1);
            end else if (deb_cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
               filt_d    = sync2_q;
               deb_cnt_d = '0;
            end else begin
               deb_cnt_d = deb_cnt_q + CNT_W'(1);
            end
         end

         always_ff @(posedge i_clk) begin
            if (i_reset) begin
               cand_q    <= 2'b00;
               deb_cnt_q <= '0;
            end else begin
               cand_q    <= cand_d;
               deb_cnt_q <= deb_cnt_d;
            end
         end
      end
   endgenerate

   logic changed, illegal, legal, dir_cw, step;

   always_comb begin
      changed = (filt_q != prev_q);
      illegal = ((filt_q ^ prev_q) == 2'b11);
      legal   = changed && !illegal;
      dir_cw  = (filt_q == cw_next(prev_q));
      state_d = state_q;
      step    = 1'b0;

      // The x1 FSM only advances on filtered changes; backtracking walks states back.
      if (illegal) begin
         state_d = ST_SYNC;
      end else begin
         case (state_q)
            ST_SYNC: if (filt_q == 2'b00) state_d = ST_IDLE;
            ST_IDLE: if (changed) state_d = (filt_q == 2'b01) ? ST_CW1 : ST_CCW1;
            ST_CW1:  if (changed) state_d = (filt_q == 2'b11) ? ST_CW2 : ST_IDLE;
            ST_CW2:  if (changed) state_d = (filt_q == 2'b10) ? ST_CW3 : ST_CW1;
            ST_CW3:  if (changed) begin
                        state_d = (filt_q == 2'b00) ? ST_IDLE : ST_CW2;
                        if (MODE == 0) step = (filt_q == 2'b00);
                     end
            ST_CCW1: if (changed) state_d = (filt_q == 2'b11) ? ST_CCW2 : ST_IDLE;
            ST_CCW2: if (changed) state_d = (filt_q == 2'b01) ? ST_CCW3 : ST_CCW1;
            ST_CCW3: if (changed) begin
                        state_d = (filt_q == 2'b00) ? ST_IDLE : ST_CCW2;
                        if (MODE == 0) step = (filt_q == 2'b00);
                     end
            default: state_d = ST_SYNC;
         endcase
      end

      if (MODE == 1)      step = legal && (filt_q == 2'b00 || filt_q == 2'b11);
      else if (MODE != 0) step = legal;

      cnt_d = step;
      err_d = illegal;
      cw_d  = step ? dir_cw : cw_q;

      pos_d = pos_q;
      if (i_clear) begin
         pos_d = '0;
      end else if (step) begin
`ifdef ROTARY_ENCODER_SAT_EN
         if (dir_cw && pos_q != {POS_WIDTH{1'b1}}) pos_d = pos_q + POS_WIDTH'(1);
         else if (!dir_cw && pos_q != '0)          pos_d = pos_q - POS_WIDTH'(1);
`else
         pos_d = dir_cw ? pos_q + POS_WIDTH'(1) : pos_q - POS_WIDTH'(1);
`endif
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         filt_q  <= 2'b00;
         prev_q  <= 2'b00;
         state_q <= ST_SYNC;
         cnt_q   <= 1'b0;
         cw_q    <= 1'b0;
         err_q   <= 1'b0;
         pos_q   <= '0;
      end else begin
         filt_q  <= filt_d;
         prev_q  <= filt_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cw_q    <= cw_d;
         err_q   <= err_d;
         pos_q   <= pos_d;
      end
   end

   assign o_cnt       = cnt_q;
   assign o_cnt_cw    = cw_q;
   assign o_cnt_err   = err_q;
   assign ov_position = pos_q;

endmodule

// File: tb/tb_rotary_encoder_counter.sv
// Directed bench for rotary_encoder_counter: four instances (x1/deb0, x1/deb4, x4, x2)
// share clock, reset and clear; each has its own phase inputs.
module tb_rotary_encoder_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr;
   logic       pa [4];
   logic       pb [4];
   logic       cnt [4];
   logic       cw [4];
   logic       err [4];
   logic [7:0] pos [4];

   int npulse [4] = '{0, 0, 0, 0};
   int nerr   [4] = '{0, 0, 0, 0};
   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   rotary_encoder_counter #(.MODE(0), .DEBOUNCE_CYCLES(0), .POS_WIDTH(8)) u_x1_d0 (
      .i_clk(clk), .i_reset(rst), .i_phase_a(pa[0]), .i_phase_b(pb[0]), .i_clear(clr),
      .o_cnt(cnt[0]), .o_cnt_cw(cw[0]), .o_cnt_err(err[0]), .ov_position(pos[0]));
   rotary_encoder_counter #(.MODE(0), .DEBOUNCE_CYCLES(4), .POS_WIDTH(8)) u_x1_d4 (
      .i_clk(clk), .i_reset(rst), .i_phase_a(pa[1]), .i_phase_b(pb[1]), .i_clear(clr),
      .o_cnt(cnt[1]), .o_cnt_cw(cw[1]), .o_cnt_err(err[1]), .ov_position(pos[1]));
   rotary_encoder_counter #(.MODE(2), .DEBOUNCE_CYCLES(0), .POS_WIDTH(8)) u_x4 (
      .i_clk(clk), .i_reset(rst), .i_phase_a(pa[2]), .i_phase_b(pb[2]), .i_clear(clr),
      .o_cnt(cnt[2]), .o_cnt_cw(cw[2]), .o_cnt_err(err[2]), .ov_position(pos[2]));
   rotary_encoder_counter #(.MODE(1), .DEBOUNCE_CYCLES(0), .POS_WIDTH(8)) u_x2 (
      .i_clk(clk), .i_reset(rst), .i_phase_a(pa[3]), .i_phase_b(pb[3]), .i_clear(clr),
      .o_cnt(cnt[3]), .o_cnt_cw(cw[3]), .o_cnt_err(err[3]), .ov_position(pos[3]));

   // Pulse counters; the stimulus only reads them after the outputs have gone quiet.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (cnt[i] === 1'b1) npulse[i]++;
         if (err[i] === 1'b1) nerr[i]++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // All stimulus tasks start and end just after a falling edge.
   task automatic drive(input int i, input logic [1:0] p, input int hold);
      pa[i] = p[0];
      pb[i] = p[1];
      repeat (hold) @(negedge clk);
   endtask

   task automatic settle();
      repeat (16) @(negedge clk);
   endtask

   task automatic cycle(input int i, input bit is_cw, input int hold);
      if (is_cw) begin
         drive(i, 2'b01, hold); drive(i, 2'b11, hold); drive(i, 2'b10, hold); drive(i, 2'b00, hold);
      end else begin
         drive(i, 2'b10, hold); drive(i, 2'b11, hold); drive(i, 2'b01, hold); drive(i, 2'b00, hold);
      end
   endtask

   // Number of falling edges from driving p until o_cnt is first seen high (-1 if never).
   task automatic measure(input int i, input logic [1:0] p, output int idx);
      pa[i] = p[0];
      pb[i] = p[1];
      idx = -1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (cnt[i] === 1'b1 && idx < 0) idx = n;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int bp, be, idx, exp_wrap;
      rst = 1'b1;
      clr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pa[i] = 1'b0;
         pb[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("reset_cnt%0d", i), cnt[i], 0);
         check($sformatf("reset_cw%0d", i),  cw[i],  0);
         check($sformatf("reset_err%0d", i), err[i], 0);
         check($sformatf("reset_pos%0d", i), pos[i], 0);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // x1, no debounce, three CW cycles at one clock per phase.
      bp = npulse[0]; be = nerr[0];
      repeat (3) cycle(0, 1'b1, 1);
      settle();
      check("t1_pulses", npulse[0] - bp, 3);
      check("t1_err",    nerr[0] - be,   0);
      check("t1_cw",     cw[0],          1);
      check("t1_pos",    pos[0],         3);

      // x1, debounce 4, ten clocks per phase: up to 3, down to 0, then one past zero.
      repeat (3) cycle(1, 1'b1, 10);
      settle();
      check("t2_pos_up", pos[1], 3);
      check("t2_cw_up",  cw[1],  1);
      bp = npulse[1];
      repeat (2) cycle(1, 1'b0, 10);
      drive(1, 2'b10, 10); drive(1, 2'b11, 10); drive(1, 2'b01, 10);
      measure(1, 2'b00, idx);
      check("t2_latency_deb4", idx, 8);
      settle();
      check("t2_pos_zero", pos[1], 0);
      check("t2_cw_ccw",   cw[1],  0);
      cycle(1, 1'b0, 10);
      settle();
`ifdef ROTARY_ENCODER_SAT_EN
      exp_wrap = 0;
`else
      exp_wrap = 255;
`endif
      check("t2_pos_past_zero", pos[1], exp_wrap);
      check("t2_pulses",        npulse[1] - bp, 4);

      // x1 glitch patterns: none of them may step.
      bp = npulse[0]; be = nerr[0];
      drive(0, 2'b01, 3); drive(0, 2'b00, 3); drive(0, 2'b10, 3); drive(0, 2'b00, 3);
      settle();
      check("t3_separate_pulses", npulse[0] - bp, 0);
      drive(0, 2'b11, 3);
      settle();
      check("t3_jump_00_11_err", nerr[0] - be, 1);
      drive(0, 2'b00, 3);
      settle();
      check("t3_jump_11_00_err", nerr[0] - be, 2);
      drive(0, 2'b10, 3); drive(0, 2'b11, 3); drive(0, 2'b10, 3); drive(0, 2'b00, 3);
      settle();
      drive(0, 2'b01, 3); drive(0, 2'b11, 3); drive(0, 2'b00, 3);
      settle();
      check("t3_no_pulses", npulse[0] - bp, 0);
      check("t3_err_total", nerr[0] - be,   3);
      check("t3_cw_held",   cw[0],          1);
      check("t3_pos_held",  pos[0],         3);
      cycle(0, 1'b1, 3);
      settle();
      check("t3_recover_pulse", npulse[0] - bp, 1);
      check("t3_recover_pos",   pos[0],         4);

      // x4: every legal transition counts.
      bp = npulse[2];
      measure(2, 2'b01, idx);
      check("t4_latency_deb0", idx, 4);
      drive(2, 2'b11, 3); drive(2, 2'b10, 3); drive(2, 2'b00, 3);
      settle();
      check("t4_x4_pulses", npulse[2] - bp, 4);
      check("t4_x4_pos",    pos[2],         4);
      check("t4_x4_cw",     cw[2],          1);
      drive(2, 2'b10, 3);
      settle();
      check("t4_x4_ccw_pos", pos[2], 3);
      check("t4_x4_ccw_dir", cw[2],  0);
      drive(2, 2'b00, 3);
      settle();
      check("t4_x4_back_pos", pos[2], 4);
      check("t4_x4_back_dir", cw[2],  1);

      // x2: only arrivals at 00 and 11 count.
      bp = npulse[3];
      cycle(3, 1'b1, 3);
      settle();
      check("t4_x2_pulses", npulse[3] - bp, 2);
      check("t4_x2_pos",    pos[3],         2);
      cycle(3, 1'b0, 3);
      settle();
      check("t4_x2_ccw_pos", pos[3],         0);
      check("t4_x2_ccw_dir", cw[3],          0);
      check("t4_x2_total",   npulse[3] - bp, 4);

      // Debounce: a 2-cycle drop of A at CCW3 would otherwise complete a CCW step.
      bp = npulse[1]; be = nerr[1];
      drive(1, 2'b10, 10); drive(1, 2'b11, 10); drive(1, 2'b01, 10);
      drive(1, 2'b00, 2);
      drive(1, 2'b01, 10);
      drive(1, 2'b11, 10); drive(1, 2'b10, 10); drive(1, 2'b00, 10);
      settle();
      check("t5_spike_pulses", npulse[1] - bp, 0);
      check("t5_spike_err",    nerr[1] - be,   0);
      check("t5_spike_pos",    pos[1],         exp_wrap);

      // Reset at CW2, released with P=00: partial progress must be lost.
      drive(0, 2'b01, 3); drive(0, 2'b11, 3);
      repeat (4) @(negedge clk);
      pa[0] = 1'b0; pb[0] = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("t6_rst_cnt", cnt[0], 0);
      check("t6_rst_cw",  cw[0],  0);
      check("t6_rst_err", err[0], 0);
      check("t6_rst_pos", pos[0], 0);
      bp = npulse[0];
      drive(0, 2'b10, 3); drive(0, 2'b00, 3);
      settle();
      check("t6_partial_pulses", npulse[0] - bp, 0);
      check("t6_partial_pos",    pos[0],         0);
      cycle(0, 1'b1, 3);
      settle();
      check("t6_full_pulses", npulse[0] - bp, 1);
      check("t6_full_pos",    pos[0],         1);

      // Clear on the same edge as a CW step: position zero, pulse still seen.
      drive(0, 2'b01, 3); drive(0, 2'b11, 3); drive(0, 2'b10, 3);
      pa[0] = 1'b0; pb[0] = 1'b0;
      repeat (3) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("t6_clr_cnt", cnt[0], 1);
      check("t6_clr_pos", pos[0], 0);
      settle();
      check("t6_clr_pos_after", pos[0], 0);
      check("t6_clr_cw",        cw[0],  1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
